// File: rtl/address_stack.sv
// rtl/address_stack.sv - 8008-style program-counter / return-address stack
// ASTACK_GUARD_EN: suppress CALL when full and RET when empty instead of wrapping.
module address_stack #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8,
  parameter int SPW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [7:0]       byte_in,
  input  logic             clear_flags,
  input  logic [SPW-1:0]   peek_sel,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] peek_out,
  output logic [SPW-1:0]   sp_out,
  output logic [SPW-1:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [2:0]       OP_INC     = 3'd1;
  localparam logic [2:0]       OP_JUMP    = 3'd2;
  localparam logic [2:0]       OP_CALL    = 3'd3;
  localparam logic [2:0]       OP_RET     = 3'd4;
  localparam logic [2:0]       OP_LOAD_LO = 3'd5;
  localparam logic [2:0]       OP_LOAD_HI = 3'd6;
  localparam logic [SPW-1:0]   SP_ONE     = SPW'(1);
  localparam logic [SPW-1:0]   LVL_MAX    = SPW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] PC_ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_entry [DEPTH];
  logic [SPW-1:0]   r_sp;
  logic [SPW-1:0]   r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_call;
  logic             w_ret;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [SPW-1:0]   w_sp_inc;
  logic [SPW-1:0]   w_sp_dec;
  logic [SPW-1:0]   w_peek_idx;

  assign w_call     = op_valid && (op == OP_CALL);
  assign w_ret      = op_valid && (op == OP_RET);
  assign w_full     = (r_level == LVL_MAX);
  assign w_empty    = (r_level == '0);
  assign w_sp_inc   = r_sp + SP_ONE;
  assign w_sp_dec   = r_sp - SP_ONE;
  assign w_peek_idx = r_sp - peek_sel;

`ifdef ASTACK_GUARD_EN
  assign w_push = w_call && !w_full;
  assign w_pop  = w_ret && !w_empty;
`else
  assign w_push = w_call;
  assign w_pop  = w_ret;
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_sp        <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      // Unguarded wrap keeps level saturated while sp still moves (8008 behaviour).
      if (w_push) begin
        r_sp              <= w_sp_inc;
        r_entry[w_sp_inc] <= addr_in;
        if (!w_full) r_level <= r_level + SP_ONE;
      end else if (w_pop) begin
        r_sp <= w_sp_dec;
        if (!w_empty) r_level <= r_level - SP_ONE;
      end else if (op_valid) begin
        case (op)
          OP_INC:     r_entry[r_sp]             <= r_entry[r_sp] + PC_ONE;
          OP_JUMP:    r_entry[r_sp]             <= addr_in;
          OP_LOAD_LO: r_entry[r_sp][7:0]        <= byte_in;
          OP_LOAD_HI: r_entry[r_sp][WIDTH-1:8]  <= byte_in[WIDTH-9:0];
          default:    ;
        endcase
      end
      r_overflow  <= (w_call && w_full) || (r_overflow && !clear_flags);
      r_underflow <= (w_ret && w_empty) || (r_underflow && !clear_flags);
    end
  end

  assign pc_out    = r_entry[r_sp];
  assign peek_out  = r_entry[w_peek_idx];
  assign sp_out    = r_sp;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_address_stack.sv
// tb/tb_address_stack.sv - randomized model-checked bench for address_stack
// Honours ASTACK_GUARD_EN for boundary expectations.
module tb_address_stack;
  localparam int W = 14;
  localparam int D = 8;
  localparam int SPW = 3;

  logic           clk = 1'b0;
  logic           clear_n = 1'b0;
  logic           op_valid = 1'b0;
  logic [2:0]     op = 3'd0;
  logic [W-1:0]   addr_in = '0;
  logic [7:0]     byte_in = 8'd0;
  logic           clear_flags = 1'b0;
  logic [SPW-1:0] peek_sel = '0;
  logic [W-1:0]   pc_out;
  logic [W-1:0]   peek_out;
  logic [SPW-1:0] sp_out;
  logic [SPW-1:0] level;
  logic           overflow;
  logic           underflow;

  address_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .clear_n(clear_n), .op_valid(op_valid), .op(op),
    .addr_in(addr_in), .byte_in(byte_in), .clear_flags(clear_flags),
    .peek_sel(peek_sel), .pc_out(pc_out), .peek_out(peek_out),
    .sp_out(sp_out), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int m_entry [D];
  int m_sp;
  int m_level;
  int m_ovf;
  int m_unf;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_entry[i] = 0;
    m_sp = 0; m_level = 0; m_ovf = 0; m_unf = 0;
  endfunction

  // The stack as a ring of D addresses; level counts return addresses held.
  function automatic void model_apply(input bit v, input int o, input int a, input int b, input bit clr);
    bit set_o = 0;
    bit set_u = 0;
    if (v) begin
      case (o)
        1: m_entry[m_sp] = (m_entry[m_sp] + 1) % (1 << W);
        2: m_entry[m_sp] = a;
        3: begin
          if (m_level == D - 1) begin
            set_o = 1;
`ifndef ASTACK_GUARD_EN
            m_sp = (m_sp + 1) % D;
            m_entry[m_sp] = a;
`endif
          end else begin
            m_sp = (m_sp + 1) % D;
            m_entry[m_sp] = a;
            m_level = m_level + 1;
          end
        end
        4: begin
          if (m_level == 0) begin
            set_u = 1;
`ifndef ASTACK_GUARD_EN
            m_sp = (m_sp + D - 1) % D;
`endif
          end else begin
            m_sp = (m_sp + D - 1) % D;
            m_level = m_level - 1;
          end
        end
        5: m_entry[m_sp] = (m_entry[m_sp] & ~32'hFF) | b;
        6: m_entry[m_sp] = (m_entry[m_sp] & 32'hFF) | ((b % (1 << (W - 8))) << 8);
        default: ;
      endcase
    end
    m_ovf = set_o ? 1 : (clr ? 0 : m_ovf);
    m_unf = set_u ? 1 : (clr ? 0 : m_unf);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc_out", pc_out, m_entry[m_sp]);
      chk("peek_out", peek_out, m_entry[(m_sp - int'(peek_sel) + D) % D]);
      chk("sp_out", sp_out, m_sp);
      chk("level", level, m_level);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
    end
  end

  task automatic step(input bit v, input int o, input int a, input int b, input bit clr, input int ps);
    op_valid = v; op = 3'(o); addr_in = W'(a); byte_in = 8'(b);
    clear_flags = clr; peek_sel = SPW'(ps);
    @(posedge clk);
    if (clear_n) model_apply(v, o, a, b, clr);
    #1;
  endtask

  task automatic do_reset();
    #2 clear_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 clear_n = 1'b1;
  endtask

  task automatic quiet();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 clear_n = 1'b1;
    cmp_en = 1'b1;
    chk("reset_pc", pc_out, 0);
    chk("reset_sp", sp_out, 0);
    chk("reset_flags", {overflow, underflow}, 0);

    repeat (3) step(1, 1, 0, 0, 0, 0);
    chk("inc3_pc", pc_out, 3);
    chk("inc3_sp", sp_out, 0);
    chk("inc3_level", level, 0);
    step(1, 2, 'h3FFF, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("inc_wrap_pc", pc_out, 0);
    chk("inc_wrap_ovf", overflow, 0);

    step(1, 2, 'h0100, 0, 0, 0);
    step(1, 3, 'h2000, 0, 0, 1);
    chk("call_pc", pc_out, 'h2000);
    chk("call_sp", sp_out, 1);
    chk("call_level", level, 1);
    chk("call_peek1", peek_out, 'h0100);
    step(1, 1, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    chk("ret_pc", pc_out, 'h0100);
    chk("ret_peek0", peek_out, 'h0100);
    chk("ret_level", level, 0);

    step(1, 2, 0, 0, 0, 0);
    step(1, 5, 0, 'hA5, 0, 0);
    step(1, 6, 0, 'hFF, 0, 0);
    chk("load_pc", pc_out, 'h3FA5);

    do_reset();
    for (int i = 1; i <= 8; i++) step(1, 3, i, 0, 0, 0);
    chk("full_ovf", overflow, 1);
    chk("full_level", level, 7);
`ifdef ASTACK_GUARD_EN
    chk("full_sp", sp_out, 7);
    chk("full_pc", pc_out, 7);
`else
    chk("full_sp", sp_out, 0);
    chk("full_pc", pc_out, 8);
`endif
    step(1, 3, 9, 0, 1, 0);
    chk("set_beats_clear", overflow, 1);
    step(0, 0, 0, 0, 1, 0);
    chk("ovf_cleared", overflow, 0);

    do_reset();
    step(1, 4, 0, 0, 0, 0);
    chk("unf_set", underflow, 1);
`ifdef ASTACK_GUARD_EN
    chk("unf_sp", sp_out, 0);
    chk("unf_pc", pc_out, 0);
`else
    chk("unf_sp", sp_out, 7);
`endif
    step(0, 0, 0, 0, 1, 0);
    chk("unf_cleared", underflow, 0);

    do_reset();
    step(1, 3, 'h0011, 0, 0, 0);
    step(1, 3, 'h0022, 0, 0, 0);
    step(1, 3, 'h1234, 0, 0, 0);
    chk("pre_rst_level", level, 3);
    chk("pre_rst_pc", pc_out, 'h1234);
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_outs", {pc_out, peek_out, sp_out, level, overflow, underflow}, 0);
    step(1, 3, 'h0777, 0, 0, 0);
    chk("op_in_reset_pc", pc_out, 0);
    chk("op_in_reset_sp", sp_out, 0);
    clear_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, (1 << W) - 1),
                $urandom_range(0, 255), $urandom_range(0, 15) == 0, $urandom_range(0, D - 1));
    end
    quiet();
    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
